// File: rtl/ay_write_sched_pkg.sv
// Shared types for the AY-3-8910 write scheduler: sequencer states and FIFO entry layout.
package ay_sched_pkg;

  localparam int AY_NUM_REGS = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ADDR  = 3'd1,
    ST_HOLD  = 3'd2,
    ST_DATA  = 3'd3,
    ST_RECOV = 3'd4
  } state_e;

  typedef struct packed {
    logic       chip;
    logic [3:0] reg_idx;
    logic [7:0] data;
  } entry_t;

endpackage

// File: rtl/ay_write_sched_if.sv
// One register-write request channel: valid/ready handshake carrying {chip, reg, data}.
interface ay_write_sched_if;
  logic       valid;
  logic       ready;
  logic       chip;
  logic [7:0] reg_idx;
  logic [7:0] data;

  modport master (output valid, chip, reg_idx, data, input ready);
  modport slave  (input valid, chip, reg_idx, data, output ready);
endinterface

// File: rtl/ay_write_sched_fifo.sv
// Synchronous FIFO for queued PSG writes; head word is visible combinationally on rdata.
module ay_sched_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 13
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [4:0]       level
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (level == 5'(DEPTH));
  assign empty   = (level == 5'd0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Storage is not reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= 5'd0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      level <= level + 5'(push_ok) - 5'(pop_ok);
    end
  end
endmodule

// File: rtl/ay_write_sched.sv
// Round-robin write scheduler sharing two AY-3-8910 PSGs between the Z80 path (r0) and
// the host injector (r1), with address-latch skipping via per-chip shadow registers.
//
// state | meaning
// IDLE  | bus quiet; pop next entry when FIFO non-empty
// ADDR  | address-latch strobe (A0=0, din=reg)
// HOLD  | chip still selected, wr_n high between strobes
// DATA  | data strobe (A0=1, din=data)
// RECOV | all deselected; last cycle may pop straight into ADDR/DATA
module ay_write_sched
  import ay_sched_pkg::*;
#(
  parameter int FIFO_DEPTH    = 4,
  parameter int STROBE_CYCLES = 2,
  parameter int GAP_CYCLES    = 1
) (
  input  logic              clk,
  input  logic              reset,
  ay_write_sched_if.slave   r0,
  ay_write_sched_if.slave   r1,
  output logic              ay_adr,
  output logic [7:0]        ay_din,
  output logic              ay_wr_n,
  output logic              ay0_cs_n,
  output logic              ay1_cs_n,
  output logic              busy,
  output logic              bad_reg,
  output logic [4:0]        fifo_level
);
  localparam logic [2:0] S_IDLE  = ST_IDLE;
  localparam logic [2:0] S_ADDR  = ST_ADDR;
  localparam logic [2:0] S_HOLD  = ST_HOLD;
  localparam logic [2:0] S_DATA  = ST_DATA;
  localparam logic [2:0] S_RECOV = ST_RECOV;

  localparam logic [3:0] STB_LOAD = 4'(STROBE_CYCLES - 1);
  localparam logic [3:0] GAP_LOAD = 4'(GAP_CYCLES - 1);

  logic       grant;
  logic       rr_ptr;
  logic       xfer;
  logic       push;
  logic       pop;
  logic       full;
  logic       empty;
  logic       req_chip;
  logic [7:0] req_reg;
  logic [7:0] req_data;
  logic       reg_ok;
  entry_t     wentry;
  entry_t     head;
  entry_t     cur;
  entry_t     cur_nxt;

  logic [2:0]       state;
  logic [2:0]       st_nxt;
  logic [3:0]       cnt;
  logic [3:0]       cnt_nxt;
  logic             sh_load;
  logic             hit;
  logic             seat_nxt;
  logic [1:0]       sh_v;
  logic [1:0][3:0]  sh;

  // Arbiter: a lone requester wins; on contention the RR pointer decides.
  always_comb begin
    if (r0.valid && r1.valid) grant = rr_ptr;
    else                      grant = r1.valid;
  end

  assign r0.ready = !reset && !full && !grant;
  assign r1.ready = !reset && !full && grant;
  assign xfer     = grant ? (r1.valid && r1.ready) : (r0.valid && r0.ready);

  assign req_chip = grant ? r1.chip    : r0.chip;
  assign req_reg  = grant ? r1.reg_idx : r0.reg_idx;
  assign req_data = grant ? r1.data    : r0.data;
  assign reg_ok   = (req_reg < 8'(AY_NUM_REGS));
  assign push     = xfer && reg_ok;
  assign wentry   = '{chip: req_chip, reg_idx: req_reg[3:0], data: req_data};

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr  <= 1'b0;
      bad_reg <= 1'b0;
    end else begin
      if (xfer) rr_ptr <= !grant;
      bad_reg <= xfer && !reg_ok;
    end
  end

  ay_sched_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(entry_t))
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata (wentry),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .level (fifo_level)
  );

  assign hit  = sh_v[head.chip] && (sh[head.chip] == head.reg_idx);
  assign busy = (state != S_IDLE) || !empty;

  always_comb begin
    st_nxt  = state;
    cnt_nxt = (cnt != 4'd0) ? cnt - 4'd1 : cnt;
    pop     = 1'b0;
    sh_load = 1'b0;
    case (state)
      S_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          st_nxt  = hit ? S_DATA : S_ADDR;
          cnt_nxt = STB_LOAD;
        end
      end
      S_ADDR: begin
        if (cnt == 4'd0) begin
          st_nxt  = S_HOLD;
          cnt_nxt = GAP_LOAD;
          sh_load = 1'b1;
        end
      end
      S_HOLD: begin
        if (cnt == 4'd0) begin
          st_nxt  = S_DATA;
          cnt_nxt = STB_LOAD;
        end
      end
      S_DATA: begin
        if (cnt == 4'd0) begin
          st_nxt  = S_RECOV;
          cnt_nxt = GAP_LOAD;
        end
      end
      S_RECOV: begin
        if (cnt == 4'd0) begin
          if (!empty) begin
            pop     = 1'b1;
            st_nxt  = hit ? S_DATA : S_ADDR;
            cnt_nxt = STB_LOAD;
          end else begin
            st_nxt  = S_IDLE;
            cnt_nxt = 4'd0;
          end
        end
      end
      default: begin
        st_nxt  = S_IDLE;
        cnt_nxt = 4'd0;
      end
    endcase
    cur_nxt  = pop ? head : cur;
    seat_nxt = (st_nxt == S_ADDR) || (st_nxt == S_HOLD) || (st_nxt == S_DATA);
  end

  // Bus pins are registered from the next state so they line up with the state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      cnt      <= 4'd0;
      cur      <= '0;
      sh_v     <= 2'b00;
      sh       <= '0;
      ay_wr_n  <= 1'b1;
      ay0_cs_n <= 1'b1;
      ay1_cs_n <= 1'b1;
      ay_adr   <= 1'b0;
      ay_din   <= 8'h00;
    end else begin
      state <= st_nxt;
      cnt   <= cnt_nxt;
      cur   <= cur_nxt;
      if (sh_load) begin
        sh_v[cur.chip] <= 1'b1;
        sh[cur.chip]   <= cur.reg_idx;
      end
      ay_wr_n  <= !((st_nxt == S_ADDR) || (st_nxt == S_DATA));
      ay0_cs_n <= !(seat_nxt && !cur_nxt.chip);
      ay1_cs_n <= !(seat_nxt && cur_nxt.chip);
      if (st_nxt == S_ADDR) begin
        ay_adr <= 1'b0;
        ay_din <= {4'h0, cur_nxt.reg_idx};
      end else if (st_nxt == S_DATA) begin
        ay_adr <= 1'b1;
        ay_din <= cur_nxt.data;
      end
    end
  end
endmodule

// File: tb/tb_ay_write_sched.sv
// Self-checking bench for ay_write_sched: transaction-level bus model plus directed scenarios.
module tb_ay_write_sched;
  localparam int DEPTH = 4;
  localparam int STB   = 2;
  localparam int GAP   = 1;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ay_adr, ay_wr_n, ay0_cs_n, ay1_cs_n, busy, bad_reg;
  logic [7:0] ay_din;
  logic [4:0] fifo_level;

  ay_write_sched_if i0();
  ay_write_sched_if i1();

  ay_write_sched #(
    .FIFO_DEPTH    (DEPTH),
    .STROBE_CYCLES (STB),
    .GAP_CYCLES    (GAP)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .r0         (i0),
    .r1         (i1),
    .ay_adr     (ay_adr),
    .ay_din     (ay_din),
    .ay_wr_n    (ay_wr_n),
    .ay0_cs_n   (ay0_cs_n),
    .ay1_cs_n   (ay1_cs_n),
    .busy       (busy),
    .bad_reg    (bad_reg),
    .fifo_level (fifo_level)
  );

  always #5 clk = ~clk;

  // Expected bus pins for one clock cycle; 'first' marks the cycle its entry leaves the FIFO.
  typedef struct packed {
    logic       wr_n;
    logic       cs0_n;
    logic       cs1_n;
    logic       adr;
    logic [7:0] din;
    logic       first;
  } cyc_t;

  cyc_t       q[$];
  cyc_t       shown;
  int         mlevel = 0;
  logic       mrr = 1'b0;
  logic [1:0] sh_v = 2'b00;
  logic [3:0] sh [2];
  logic       exp_busy = 1'b0;
  logic       exp_bad = 1'b0;
  logic       acc0 = 1'b0;
  logic       acc1 = 1'b0;
  logic       started = 1'b0;

  int checks = 0;
  int errors = 0;
  int n_cs0, n_cs1, n_astb, n_dstb, n_bad, n_busy, max_lvl;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out at %0t", name, $time);
  endtask

  function automatic logic m_grant();
    if (i0.valid && i1.valid) return mrr;
    return i1.valid;
  endfunction

  function automatic logic m_ready(input logic n);
    return !reset && (mlevel < DEPTH) && (m_grant() == n);
  endfunction

  // Expand one write into its cycle-by-cycle bus picture, honouring the per-chip shadow.
  task automatic append(input logic chip, input logic [3:0] r, input logic [7:0] d);
    cyc_t c;
    logic h;
    h = sh_v[chip] && (sh[chip] == r);
    c.cs0_n = chip;
    c.cs1_n = !chip;
    c.first = 1'b1;
    if (!h) begin
      for (int i = 0; i < STB; i++) begin
        c.wr_n = 1'b0; c.adr = 1'b0; c.din = {4'h0, r};
        q.push_back(c);
        c.first = 1'b0;
      end
      for (int i = 0; i < GAP; i++) begin
        c.wr_n = 1'b1;
        q.push_back(c);
      end
      sh_v[chip] = 1'b1;
      sh[chip]   = r;
    end
    for (int i = 0; i < STB; i++) begin
      c.wr_n = 1'b0; c.adr = 1'b1; c.din = d;
      q.push_back(c);
      c.first = 1'b0;
    end
    for (int i = 0; i < GAP; i++) begin
      c.wr_n = 1'b1; c.cs0_n = 1'b1; c.cs1_n = 1'b1;
      q.push_back(c);
    end
  endtask

  always @(posedge clk) begin
    logic       g, act, c;
    logic [7:0] r, d;
    started = 1'b1;
    acc0 = 1'b0;
    acc1 = 1'b0;
    if (reset) begin
      q.delete();
      mlevel   = 0;
      mrr      = 1'b0;
      sh_v     = 2'b00;
      shown    = '{wr_n: 1'b1, cs0_n: 1'b1, cs1_n: 1'b1, adr: 1'b0, din: 8'h00, first: 1'b0};
      exp_busy = 1'b0;
      exp_bad  = 1'b0;
    end else begin
      g    = m_grant();
      acc0 = i0.valid && m_ready(1'b0);
      acc1 = i1.valid && m_ready(1'b1);
      exp_bad = 1'b0;
      if (q.size() > 0) begin
        shown = q.pop_front();
        if (shown.first) mlevel--;
        act = 1'b1;
      end else begin
        shown.wr_n = 1'b1; shown.cs0_n = 1'b1; shown.cs1_n = 1'b1; shown.first = 1'b0;
        act = 1'b0;
      end
      if (acc0 || acc1) begin
        mrr = !g;
        if (acc0) begin c = i0.chip; r = i0.reg_idx; d = i0.data; end
        else      begin c = i1.chip; r = i1.reg_idx; d = i1.data; end
        if (r > 8'd15) exp_bad = 1'b1;
        else begin
          mlevel++;
          append(c, r[3:0], d);
        end
      end
      exp_busy = act || (mlevel > 0);
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("wr_n",       ay_wr_n,    shown.wr_n);
      chk("ay0_cs_n",   ay0_cs_n,   shown.cs0_n);
      chk("ay1_cs_n",   ay1_cs_n,   shown.cs1_n);
      chk("ay_adr",     ay_adr,     shown.adr);
      chk("ay_din",     ay_din,     shown.din);
      chk("busy",       busy,       exp_busy);
      chk("bad_reg",    bad_reg,    exp_bad);
      chk("fifo_level", fifo_level, mlevel);
      chk("r0_ready",   i0.ready,   m_ready(1'b0));
      chk("r1_ready",   i1.ready,   m_ready(1'b1));
      if (!ay0_cs_n) n_cs0++;
      if (!ay1_cs_n) n_cs1++;
      if (!ay_wr_n && !ay_adr) n_astb++;
      if (!ay_wr_n && ay_adr) n_dstb++;
      if (bad_reg) n_bad++;
      if (busy) n_busy++;
      if (int'(fifo_level) > max_lvl) max_lvl = int'(fifo_level);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_counts();
    n_cs0 = 0; n_cs1 = 0; n_astb = 0; n_dstb = 0; n_bad = 0; n_busy = 0; max_lvl = 0;
  endtask

  task automatic set_req(input int p, input logic chip, input logic [7:0] r, input logic [7:0] d);
    if (p == 0) begin i0.valid = 1'b1; i0.chip = chip; i0.reg_idx = r; i0.data = d; end
    else        begin i1.valid = 1'b1; i1.chip = chip; i1.reg_idx = r; i1.data = d; end
  endtask

  task automatic do_write(input int p, input logic chip, input logic [7:0] r, input logic [7:0] d);
    set_req(p, chip, r, d);
    for (int n = 0; n < 100; n++) begin
      tick();
      if ((p == 0 && acc0) || (p == 1 && acc1)) begin
        if (p == 0) i0.valid = 1'b0; else i1.valid = 1'b0;
        return;
      end
    end
    i0.valid = 1'b0;
    i1.valid = 1'b0;
    fail("write_accept");
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 300; n++) begin
      tick();
      if (q.size() == 0 && mlevel == 0 && !exp_busy) return;
    end
    fail("wait_idle");
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  int gseq [12];
  int ng, k0, k1;
  int found;

  initial begin
    i0.valid = 1'b0; i0.chip = 1'b0; i0.reg_idx = 8'h00; i0.data = 8'h00;
    i1.valid = 1'b0; i1.chip = 1'b0; i1.reg_idx = 8'h00; i1.data = 8'h00;
    clear_counts();
    tick();
    tick();
    reset = 1'b0;
    chk("reset_busy", busy, 1'b0);
    chk("reset_level", fifo_level, 5'd0);

    // Single write, full address + data transaction
    clear_counts();
    do_write(0, 1'b0, 8'd7, 8'h38);
    wait_idle();
    chk("single_cs0_cycles", n_cs0, 5);
    chk("single_addr_strobes", n_astb, 2);
    chk("single_data_strobes", n_dstb, 2);
    chk("single_cs1_cycles", n_cs1, 0);
    chk("single_busy_cycles", n_busy, 7);

    // Same chip/reg again: address cycle skipped
    clear_counts();
    do_write(0, 1'b0, 8'd7, 8'h3F);
    wait_idle();
    chk("hit_addr_strobes", n_astb, 0);
    chk("hit_data_strobes", n_dstb, 2);
    chk("hit_busy_cycles", n_busy, 4);

    // Other chip, same reg: its shadow is independent
    clear_counts();
    do_write(1, 1'b1, 8'd7, 8'h11);
    wait_idle();
    chk("chip1_addr_strobes", n_astb, 2);
    chk("chip1_cs1_cycles", n_cs1, 5);
    chk("chip1_cs0_cycles", n_cs0, 0);

    // Contention: both requesters hold valid for 6 writes each
    do_reset();
    clear_counts();
    k0 = 0; k1 = 0; ng = 0;
    set_req(0, 1'b0, 8'd0, 8'h10);
    set_req(1, 1'b1, 8'd0, 8'h20);
    for (int n = 0; n < 200 && (k0 < 6 || k1 < 6); n++) begin
      tick();
      if (acc0) begin
        if (ng < 12) gseq[ng] = 0;
        ng++; k0++;
        if (k0 < 6) set_req(0, 1'b0, 8'(k0), 8'(8'h10 + k0)); else i0.valid = 1'b0;
      end
      if (acc1) begin
        if (ng < 12) gseq[ng] = 1;
        ng++; k1++;
        if (k1 < 6) set_req(1, 1'b1, 8'(k1), 8'(8'h20 + k1)); else i1.valid = 1'b0;
      end
    end
    if (k0 < 6 || k1 < 6) fail("contention_accept");
    wait_idle();
    for (int i = 0; i < 12 && i < ng; i++) chk("grant_order", gseq[i], i % 2);
    chk("contention_max_level", max_lvl, DEPTH);
    chk("contention_addr_strobes", n_astb, 24);
    chk("contention_data_strobes", n_dstb, 24);

    // Out-of-range register: consumed, flagged, never sequenced
    clear_counts();
    do_write(1, 1'b0, 8'h10, 8'h99);
    chk("bad_level", fifo_level, 5'd0);
    wait_idle();
    chk("bad_pulse_cycles", n_bad, 1);
    chk("bad_bus_cycles", n_cs0 + n_cs1, 0);

    // Reset while the data strobe is on the bus
    do_write(0, 1'b0, 8'd9, 8'h55);
    found = 0;
    for (int n = 0; n < 50; n++) begin
      tick();
      if (shown.adr && !shown.wr_n) begin found = 1; break; end
    end
    if (found == 0) fail("reach_data_state");
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_wr_n", ay_wr_n, 1'b1);
    chk("abort_cs0_n", ay0_cs_n, 1'b1);
    chk("abort_cs1_n", ay1_cs_n, 1'b1);
    chk("abort_level", fifo_level, 5'd0);
    clear_counts();
    do_write(0, 1'b0, 8'd9, 8'h66);
    wait_idle();
    chk("post_reset_addr_strobes", n_astb, 2);

    // Four queued writes run back-to-back through RECOV
    clear_counts();
    do_write(0, 1'b1, 8'd8,  8'hA0);
    do_write(0, 1'b1, 8'd9,  8'hA1);
    do_write(0, 1'b1, 8'd10, 8'hA2);
    do_write(0, 1'b1, 8'd11, 8'hA3);
    wait_idle();
    chk("b2b_busy_cycles", n_busy, 25);
    chk("b2b_cs1_cycles", n_cs1, 20);
    chk("b2b_addr_strobes", n_astb, 8);

    tick();
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish at %0t", $time);
    $fatal(1, "watchdog expired");
  end
endmodule
